// File: rtl/chirp_ctrl_pkg.sv
// Shared opcodes, state encoding and reset constants for the chirp command sequencer.
// Build option: CHIRP_SEQ_PREAMBLE_EN adds the preamble state to the state encoding.
package chirp_ctrl_pkg;

    localparam logic [7:0] OP_CFG   = 8'hA1;
    localparam logic [7:0] OP_LOAD  = 8'hA2;
    localparam logic [7:0] OP_START = 8'hA3;
    localparam logic [7:0] OP_ABORT = 8'hA4;

    localparam int PREAMBLE_LEN = 8;

    localparam logic [3:0] SF_MIN = 4'd7;
    localparam logic [3:0] SF_MAX = 4'd12;
    localparam logic [3:0] SF_RST = 4'd7;
    localparam int unsigned BW_RST  = 0;
    localparam int unsigned DIV_RST = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_ARG,
        ST_LOAD_LEN,
        ST_LOAD_DATA,
        ST_TX_ISSUE,
        ST_TX_WAIT
`ifdef CHIRP_SEQ_PREAMBLE_EN
        , ST_PREAMBLE
`endif
    } state_e;

    function automatic logic sf_in_range(input logic [3:0] sf);
        return (sf >= SF_MIN) && (sf <= SF_MAX);
    endfunction

endpackage

// File: rtl/chirp_sym_ram.sv
// Symbol buffer for the chirp sequencer: synchronous write port, asynchronous read port.
module chirp_sym_ram
    import chirp_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    logic [WORD_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    // NOTE: the array has no reset so it maps onto plain storage cells; only words written by a LOAD are ever read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/chirp_seq_ctrl.sv
// Command parser and transmit sequencer between the UART RX byte stream and the chirp generator.
// Build option: CHIRP_SEQ_PREAMBLE_EN prefixes every transmission with symbol-0 preamble chirps.
module chirp_seq_ctrl
    import chirp_ctrl_pkg::*;
#(
    parameter int MAX_SF_WIDTH     = 8,
    parameter int BW_BITWIDTH      = 2,
    parameter int ADDR_WIDTH       = 6,
    parameter int DATA_WIDTH       = 8,
    parameter int DIVIDER_BITWIDTH = 7
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rx_valid,
    input  logic [DATA_WIDTH-1:0]       i_rx_data,
    input  logic                        i_chirp_done,
    output logic [3:0]                  o_sf,
    output logic [BW_BITWIDTH-1:0]      o_bw,
    output logic [DIVIDER_BITWIDTH-1:0] o_div,
    output logic [MAX_SF_WIDTH-1:0]     o_symbol,
    output logic                        o_chirp_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0]      LEN_ONE = LEN_W'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

    state_e                        state_q, state_d;
    logic [1:0]                    cfg_cnt_q, cfg_cnt_d;
    logic [3:0]                    sf_arg_q, sf_arg_d;
    logic [BW_BITWIDTH-1:0]        bw_arg_q, bw_arg_d;
    logic [LEN_W-1:0]              len_q, len_d;
    logic [ADDR_WIDTH-1:0]         wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH-1:0]         idx_q, idx_d;
    logic [3:0]                    sf_q, sf_d;
    logic [BW_BITWIDTH-1:0]        bw_q, bw_d;
    logic [DIVIDER_BITWIDTH-1:0]   div_q, div_d;
    logic [MAX_SF_WIDTH-1:0]       symbol_q, symbol_d;
    logic                          chirp_start_q, chirp_start_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
`ifdef CHIRP_SEQ_PREAMBLE_EN
    logic [2:0]                    pre_cnt_q, pre_cnt_d;
    logic                          pre_wait_q, pre_wait_d;
`endif

    logic                          ram_we;
    logic [ADDR_WIDTH-1:0]         ram_raddr;
    logic [MAX_SF_WIDTH-1:0]       ram_rdata;
    logic                          rx_abort;
    logic                          rx_len_bad;
    logic                          last_wr;
    logic                          last_sym;

    assign rx_abort   = i_rx_valid && (i_rx_data == OP_ABORT);
    assign rx_len_bad = (i_rx_data == '0) || (int'(i_rx_data) > DEPTH);
    assign last_wr    = (LEN_W'(wr_idx_q) == (len_q - LEN_ONE));
    assign last_sym   = (LEN_W'(idx_q) == (len_q - LEN_ONE));
    assign ram_we     = (state_q == ST_LOAD_DATA) && i_rx_valid;
    // In IDLE the read port already points at word 0 so START can issue the first symbol immediately.
    assign ram_raddr  = (state_q == ST_IDLE) ? '0 : idx_q;

    chirp_sym_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (MAX_SF_WIDTH)
    ) u_sym_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (wr_idx_q),
        .i_wdata (i_rx_data[MAX_SF_WIDTH-1:0]),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    // NOTE: every path assigns a default first, so no partially-assigned signal can infer a latch.
    always_comb begin
        state_d       = state_q;
        cfg_cnt_d     = cfg_cnt_q;
        sf_arg_d      = sf_arg_q;
        bw_arg_d      = bw_arg_q;
        len_d         = len_q;
        wr_idx_d      = wr_idx_q;
        idx_d         = idx_q;
        sf_d          = sf_q;
        bw_d          = bw_q;
        div_d         = div_q;
        symbol_d      = symbol_q;
        chirp_start_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
`ifdef CHIRP_SEQ_PREAMBLE_EN
        pre_cnt_d     = pre_cnt_q;
        pre_wait_d    = pre_wait_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        OP_CFG: begin
                            cfg_cnt_d = '0;
                            state_d   = ST_CFG_ARG;
                        end
                        OP_LOAD: state_d = ST_LOAD_LEN;
                        OP_START: begin
                            if (len_q == '0) begin
                                err_d = 1'b1;
                            end else begin
                                busy_d        = 1'b1;
                                idx_d         = '0;
                                chirp_start_d = 1'b1;
`ifdef CHIRP_SEQ_PREAMBLE_EN
                                symbol_d   = '0;
                                pre_cnt_d  = '0;
                                pre_wait_d = 1'b1;
                                state_d    = ST_PREAMBLE;
`else
                                // First issue rides on the START edge; TX_ISSUE serves the later symbols.
                                symbol_d = ram_rdata;
                                state_d  = ST_TX_WAIT;
`endif
                            end
                        end
                        OP_ABORT: state_d = ST_IDLE;
                        default:  err_d   = 1'b1;
                    endcase
                end
            end

            ST_CFG_ARG: begin
                if (i_rx_valid) begin
                    case (cfg_cnt_q)
                        2'd0: begin
                            sf_arg_d  = i_rx_data[3:0];
                            cfg_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            bw_arg_d  = i_rx_data[BW_BITWIDTH-1:0];
                            cfg_cnt_d = 2'd2;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            if (sf_in_range(sf_arg_q)) begin
                                sf_d  = sf_arg_q;
                                bw_d  = bw_arg_q;
                                div_d = i_rx_data[DIVIDER_BITWIDTH-1:0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_LOAD_LEN: begin
                if (i_rx_valid) begin
                    if (rx_len_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d    = i_rx_data[LEN_W-1:0];
                        wr_idx_d = '0;
                        state_d  = ST_LOAD_DATA;
                    end
                end
            end

            ST_LOAD_DATA: begin
                if (i_rx_valid) begin
                    if (last_wr) begin
                        state_d = ST_IDLE;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_ONE;
                    end
                end
            end

            ST_TX_ISSUE: begin
                if (rx_abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    chirp_start_d = 1'b1;
                    symbol_d      = ram_rdata;
                    state_d       = ST_TX_WAIT;
                end
            end

            ST_TX_WAIT: begin
                if (rx_abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (i_chirp_done) begin
                    if (last_sym) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_TX_ISSUE;
                    end
                end
            end

`ifdef CHIRP_SEQ_PREAMBLE_EN
            ST_PREAMBLE: begin
                if (rx_abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!pre_wait_q) begin
                    chirp_start_d = 1'b1;
                    symbol_d      = '0;
                    pre_wait_d    = 1'b1;
                end else if (i_chirp_done) begin
                    if (pre_cnt_q == 3'(PREAMBLE_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = ST_TX_ISSUE;
                    end else begin
                        pre_cnt_d  = pre_cnt_q + 3'd1;
                        pre_wait_d = 1'b0;
                    end
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            cfg_cnt_q     <= '0;
            sf_arg_q      <= '0;
            bw_arg_q      <= '0;
            len_q         <= '0;
            wr_idx_q      <= '0;
            idx_q         <= '0;
            sf_q          <= SF_RST;
            bw_q          <= BW_BITWIDTH'(BW_RST);
            div_q         <= DIVIDER_BITWIDTH'(DIV_RST);
            symbol_q      <= '0;
            chirp_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef CHIRP_SEQ_PREAMBLE_EN
            pre_cnt_q     <= '0;
            pre_wait_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cfg_cnt_q     <= cfg_cnt_d;
            sf_arg_q      <= sf_arg_d;
            bw_arg_q      <= bw_arg_d;
            len_q         <= len_d;
            wr_idx_q      <= wr_idx_d;
            idx_q         <= idx_d;
            sf_q          <= sf_d;
            bw_q          <= bw_d;
            div_q         <= div_d;
            symbol_q      <= symbol_d;
            chirp_start_q <= chirp_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
`ifdef CHIRP_SEQ_PREAMBLE_EN
            pre_cnt_q     <= pre_cnt_d;
            pre_wait_q    <= pre_wait_d;
`endif
        end
    end

    assign o_sf          = sf_q;
    assign o_bw          = bw_q;
    assign o_div         = div_q;
    assign o_symbol      = symbol_q;
    assign o_chirp_start = chirp_start_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_chirp_seq_ctrl.sv
// Self-checking bench for chirp_seq_ctrl: directed byte sequences, a scoreboard of expected chirp symbols,
// and a generator model answering each start with a done strobe two cycles later.
module tb_chirp_seq_ctrl;
    import chirp_ctrl_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       i_chirp_done;
    logic [3:0] o_sf;
    logic [1:0] o_bw;
    logic [6:0] o_div;
    logic [7:0] o_symbol;
    logic       o_chirp_start;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    logic auto_done;
    logic auto_pulse;
    logic man_done;
    assign i_chirp_done = auto_pulse | man_done;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [7:0] exp_q[$];
    int start_cyc[$];

    chirp_seq_ctrl #(
        .MAX_SF_WIDTH     (8),
        .BW_BITWIDTH      (2),
        .ADDR_WIDTH       (6),
        .DATA_WIDTH       (8),
        .DIVIDER_BITWIDTH (7)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .i_chirp_done  (i_chirp_done),
        .o_sf          (o_sf),
        .o_bw          (o_bw),
        .o_div         (o_div),
        .o_symbol      (o_symbol),
        .o_chirp_start (o_chirp_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #50 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic push_preamble();
`ifdef CHIRP_SEQ_PREAMBLE_EN
        for (int i = 0; i < PREAMBLE_LEN; i++) exp_q.push_back(8'h00);
`endif
    endtask

    task automatic wait_tx_end(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (o_busy && n < max_cycles) begin
            tick(1);
            n++;
        end
        check({tag, "_busy_low"}, o_busy, 1'b0);
    endtask

    // Generator model: a done strobe two cycles after each observed start.
    initial begin
        auto_pulse = 1'b0;
        forever begin
            @(posedge i_clk);
            #2;
            auto_pulse = 1'b0;
            if (auto_done && o_chirp_start) begin
                repeat (2) @(posedge i_clk);
                #2;
                auto_pulse = 1'b1;
            end
        end
    end

    // Output monitor: pops the scoreboard on every chirp start.
    always @(negedge i_clk) begin
        if (o_done) done_cnt++;
        if (o_err)  err_cnt++;
        if (o_chirp_start) begin
            start_cyc.push_back(cyc);
            check("start_while_busy", o_busy, 1'b1);
            if (exp_q.size() == 0) check("unexpected_start", o_chirp_start, 1'b0);
            else                   check("start_symbol", o_symbol, exp_q.pop_front());
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int e0;
        logic [7:0] sym;

        i_rst      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        man_done   = 1'b0;
        auto_done  = 1'b0;
        tick(3);
        i_rst = 1'b0;

        check("rst_sf",     o_sf, 4'd7);
        check("rst_bw",     o_bw, 2'd0);
        check("rst_div",    o_div, 7'd1);
        check("rst_symbol", o_symbol, 8'h00);
        check("rst_start",  o_chirp_start, 1'b0);
        check("rst_busy",   o_busy, 1'b0);
        check("rst_done",   o_done, 1'b0);
        check("rst_err",    o_err, 1'b0);

        // START with nothing loaded, unknown opcode, stray done in IDLE
        send_byte(8'hA3);
        check("start_len0_err",  o_err, 1'b1);
        check("start_len0_busy", o_busy, 1'b0);
        tick(1);
        check("err_is_pulse", o_err, 1'b0);
        send_byte(8'h55);
        check("bad_opcode_err", o_err, 1'b1);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        check("idle_done_ignored", o_done, 1'b0);
        check("idle_done_no_start", o_chirp_start, 1'b0);

        // Configuration commands
        send_byte(8'hA1); send_byte(8'h09); send_byte(8'h02);
        check("cfg_not_before_byte3", o_sf, 4'd7);
        send_byte(8'h10);
        check("cfg1_sf",  o_sf, 4'd9);
        check("cfg1_bw",  o_bw, 2'd2);
        check("cfg1_div", o_div, 7'h10);
        send_byte(8'hA1); send_byte(8'h0D); send_byte(8'h00); send_byte(8'h00);
        check("cfg_sf13_err", o_err, 1'b1);
        check("cfg_sf13_sf",  o_sf, 4'd9);
        check("cfg_sf13_bw",  o_bw, 2'd2);
        check("cfg_sf13_div", o_div, 7'h10);
        send_byte(8'hA1); send_byte(8'h07); send_byte(8'h01); send_byte(8'h05);
        check("cfg_sf7_sf",  o_sf, 4'd7);
        check("cfg_sf7_err", o_err, 1'b0);
        check("cfg_sf7_div", o_div, 7'h05);
        send_byte(8'hA1); send_byte(8'h0C); send_byte(8'h03); send_byte(8'h7F);
        check("cfg_sf12_sf",  o_sf, 4'd12);
        check("cfg_sf12_bw",  o_bw, 2'd3);
        check("cfg_sf12_div", o_div, 7'h7F);
        send_byte(8'hA1); send_byte(8'h06); send_byte(8'h01); send_byte(8'h01);
        check("cfg_sf6_err", o_err, 1'b1);
        check("cfg_sf6_sf",  o_sf, 4'd12);

        // Length bounds
        send_byte(8'hA2); send_byte(8'h00);
        check("len0_err", o_err, 1'b1);
        send_byte(8'hA2); send_byte(8'h41);
        check("len65_err", o_err, 1'b1);
        send_byte(8'hA3);
        check("len_still0_err", o_err, 1'b1);

        // Three-symbol frame with bytes arriving during transmission
        send_byte(8'hA2); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        push_preamble();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        start_cyc.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        auto_done = 1'b1;
        send_byte(8'hA3);
        check("start_latency_pulse", o_chirp_start, 1'b1);
        check("start_latency_busy",  o_busy, 1'b1);
        send_byte(8'hA1); send_byte(8'h0B); send_byte(8'h00); send_byte(8'h00);
        wait_tx_end("frame3", 400);
        tick(2);
        check("frame3_done_once", done_cnt - d0, 1);
        check("frame3_no_err",    err_cnt - e0, 0);
        check("frame3_all_starts", exp_q.size(), 0);
        check("frame3_sf_kept",   o_sf, 4'd12);
        check("frame3_div_kept",  o_div, 7'h7F);
        for (int i = 1; i < start_cyc.size(); i++) check("start_spacing", start_cyc[i] - start_cyc[i-1], 4);

        // ABORT coinciding with the first done
        auto_done = 1'b0;
        send_byte(8'hA2); send_byte(8'h04);
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
`ifdef CHIRP_SEQ_PREAMBLE_EN
        exp_q.push_back(8'h00);
`else
        exp_q.push_back(8'hA0);
`endif
        d0 = done_cnt;
        send_byte(8'hA3);
        tick(1);
        man_done = 1'b1;
        send_byte(8'hA4);
        man_done = 1'b0;
        check("abort_busy_low", o_busy, 1'b0);
        check("abort_no_done",  o_done, 1'b0);
        tick(10);
        check("abort_done_count", done_cnt - d0, 0);
        check("abort_first_start_seen", exp_q.size(), 0);
        push_preamble();
        for (int i = 0; i < 4; i++) begin
            sym = 8'hA0 + 8'(i);
            exp_q.push_back(sym);
        end
        d0 = done_cnt;
        auto_done = 1'b1;
        send_byte(8'hA3);
        wait_tx_end("replay", 400);
        tick(2);
        check("replay_done_once", done_cnt - d0, 1);
        check("replay_all_starts", exp_q.size(), 0);

        // Single-symbol frame
        send_byte(8'hA2); send_byte(8'h01); send_byte(8'h7F);
        push_preamble();
        exp_q.push_back(8'h7F);
        d0 = done_cnt;
        send_byte(8'hA3);
        wait_tx_end("single", 400);
        tick(2);
        check("single_done_once", done_cnt - d0, 1);
        check("single_all_starts", exp_q.size(), 0);

        // Full-depth frame
        send_byte(8'hA2); send_byte(8'h40);
        for (int i = 0; i < 64; i++) begin
            sym = 8'(i * 5 + 3);
            send_byte(sym);
        end
        push_preamble();
        for (int i = 0; i < 64; i++) begin
            sym = 8'(i * 5 + 3);
            exp_q.push_back(sym);
        end
        d0 = done_cnt;
        send_byte(8'hA3);
        wait_tx_end("full", 2000);
        tick(2);
        check("full_done_once", done_cnt - d0, 1);
        check("full_all_starts", exp_q.size(), 0);

        // Reset in the middle of a CFG command
        auto_done = 1'b0;
        send_byte(8'hA1); send_byte(8'h0B);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        check("midrst_sf",   o_sf, 4'd7);
        check("midrst_bw",   o_bw, 2'd0);
        check("midrst_div",  o_div, 7'd1);
        check("midrst_busy", o_busy, 1'b0);
        send_byte(8'h00);
        check("midrst_partial_dropped", o_err, 1'b1);
        send_byte(8'hA3);
        check("midrst_len_cleared", o_err, 1'b1);
        check("midrst_no_start", o_chirp_start, 1'b0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
